// File: rtl/ram_burst_rd_if.sv
// Output word stream of the RAM burst reader.
// Ports: valid_o/data_o from master, ready_i from slave.
interface ram_burst_rd_if #(
  parameter int Word_Width = 32
) ();
  logic                  valid_o;
  logic                  ready_i;
  logic [Word_Width-1:0] data_o;

  modport master (
    output valid_o,
    output data_o,
    input  ready_i
  );

  modport slave (
    input  valid_o,
    input  data_o,
    output ready_i
  );
endinterface

// File: rtl/ram_burst_rd.sv
// Burst read initiator for one RAM port, streaming words out.
// Ports: clk, rst_n, start_i/base_i/len_i request, busy_o/done_o
// status, ram_* port (active-low cen/oen/wen, 1-cycle read),
// strm (valid/ready/data). Optional RAM_BURST_RD_STRIDE_EN adds
// stride_i, the per-read address increment.
module ram_burst_rd #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8,
  parameter int Len_Width  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [Addr_Width-1:0] base_i,
  input  logic [Len_Width-1:0]  len_i,
`ifdef RAM_BURST_RD_STRIDE_EN
  input  logic [Addr_Width-1:0] stride_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_cen_o,
  output logic                  ram_oen_o,
  output logic                  ram_wen_o,
  output logic [Addr_Width-1:0] ram_addr_o,
  input  logic [Word_Width-1:0] ram_data_i,
  ram_burst_rd_if.master        strm
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [Addr_Width-1:0] addr;
  logic [Addr_Width-1:0] step;
  logic [Len_Width-1:0]  iss_left;
  logic [Len_Width-1:0]  pend;
  logic                  inflight;
  logic                  done_q;

  logic [Word_Width-1:0] fifo_q [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            cnt;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  last_pop;
  logic [2:0]            load;

`ifdef RAM_BURST_RD_STRIDE_EN
  logic [Addr_Width-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = {{(Addr_Width-1){1'b0}}, 1'b1};
`endif

  assign push     = inflight;
  assign pop      = strm.valid_o & strm.ready_i;
  assign last_pop = pop && (pend == Len_Width'(1));

  // Credit check: words buffered plus the read in flight,
  // less the word leaving now, must leave a free slot.
  assign load  = {1'b0, cnt} + {2'b00, inflight};
  assign issue = (state == ISSUE) &&
                 (load < (3'd2 + {2'b00, pop}));

  assign busy_o     = (state != IDLE);
  assign done_o     = done_q;
  assign ram_cen_o  = ~issue;
  assign ram_oen_o  = (state == IDLE);
  assign ram_wen_o  = 1'b1;
  assign ram_addr_o = addr;

  assign strm.valid_o = (cnt != 2'd0);
  assign strm.data_o  = fifo_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      iss_left <= '0;
      pend     <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
`ifdef RAM_BURST_RD_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (issue) addr <= addr + step;
      if (pop)   pend <= pend - Len_Width'(1);
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state    <= ISSUE;
              addr     <= base_i;
              iss_left <= len_i;
              pend     <= len_i;
`ifdef RAM_BURST_RD_STRIDE_EN
              stride_q <= stride_i;
`endif
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            iss_left <= iss_left - Len_Width'(1);
            if (iss_left == Len_Width'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      cnt       <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= ram_data_i;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && (cnt == 2'd2))
  );

endmodule

// File: tb/tb_ram_burst_rd.sv
// Self-checking bench for ram_burst_rd with a RAM model.
// Table of bursts plus hand-written reset-mid-burst sequence.
module tb_ram_burst_rd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base;
  logic [8:0]  len;
  logic [7:0]  stride;
  logic        busy;
  logic        done;
  logic        cen;
  logic        oen;
  logic        wen;
  logic [7:0]  addr;
  logic [31:0] ram_rd;

  int n_checks;
  int n_fail;

  ram_burst_rd_if #(.Word_Width(32)) sif ();

  ram_burst_rd #(
    .Word_Width(32),
    .Addr_Width(8),
    .Len_Width (9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .base_i    (base),
    .len_i     (len),
`ifdef RAM_BURST_RD_STRIDE_EN
    .stride_i  (stride),
`endif
    .busy_o    (busy),
    .done_o    (done),
    .ram_cen_o (cen),
    .ram_oen_o (oen),
    .ram_wen_o (wen),
    .ram_addr_o(addr),
    .ram_data_i(ram_rd),
    .strm      (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: mem[a] = a + 0x100, one-cycle registered read.
  initial ram_rd = 32'h0;
  always @(posedge clk)
    if (!cen) ram_rd <= 32'h100 + {24'h0, addr};

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [7:0]  stride;
    logic [15:0] pat;
    logic [7:0]  last_addr;
    int          done_at;
    bit          mid_start;
  } vec_t;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_busy"},  32'(busy),        32'd0);
    check({pfx, "_done"},  32'(done),        32'd0);
    check({pfx, "_cen"},   32'(cen),         32'd1);
    check({pfx, "_oen"},   32'(oen),         32'd1);
    check({pfx, "_wen"},   32'(wen),         32'd1);
    check({pfx, "_addr"},  32'(addr),        32'd0);
    check({pfx, "_valid"}, 32'(sif.valid_o), 32'd0);
    check({pfx, "_data"},  sif.data_o,       32'd0);
  endtask

  task automatic run_burst(input vec_t v, input int id);
    int          nis;
    int          npop;
    int          done_k;
    bit          stall;
    logic [31:0] held;
    logic [7:0]  last;
    logic [7:0]  ea;
    nis    = 0;
    npop   = 0;
    done_k = 0;
    stall  = 1'b0;
    held   = 32'h0;
    last   = 8'h0;
    @(negedge clk);
    start       = 1'b1;
    base        = v.base;
    len         = v.len;
    stride      = v.stride;
    sif.ready_i = v.pat[0];
    #1;
    check($sformatf("v%0d_busy_t0", id), 32'(busy), 32'd0);
    for (int k = 1; k <= 300 && done_k == 0; k++) begin
      @(negedge clk);
      start       = 1'b0;
      sif.ready_i = v.pat[k % 16];
      if (v.mid_start && k == 3) begin
        start = 1'b1;
        base  = 8'h99;
        len   = 9'd2;
      end
      #1;
      if (stall) begin
        check($sformatf("v%0d_stall_valid", id),
              32'(sif.valid_o), 32'd1);
        check($sformatf("v%0d_stall_data", id),
              sif.data_o, held);
      end
      check($sformatf("v%0d_oen", id), 32'(oen), 32'(!busy));
      check($sformatf("v%0d_wen", id), 32'(wen), 32'd1);
      if (!cen) begin
        ea = v.base + 8'(nis) * v.stride;
        check($sformatf("v%0d_addr%0d", id, nis),
              32'(addr), 32'(ea));
        last = addr;
        nis++;
      end
      if (sif.valid_o && sif.ready_i) begin
        ea = v.base + 8'(npop) * v.stride;
        check($sformatf("v%0d_data%0d", id, npop),
              sif.data_o, 32'h100 + {24'h0, ea});
        npop++;
      end
      stall = sif.valid_o && !sif.ready_i;
      held  = sif.data_o;
      check($sformatf("v%0d_window", id),
            32'((nis - npop) <= 2), 32'd1);
      if (done) done_k = k;
      else check($sformatf("v%0d_busy", id),
                 32'(busy), 32'(v.len != 0));
    end
    check($sformatf("v%0d_done_seen", id),
          32'(done_k != 0), 32'd1);
    check($sformatf("v%0d_issued", id), 32'(nis), 32'(v.len));
    check($sformatf("v%0d_popped", id), 32'(npop), 32'(v.len));
    check($sformatf("v%0d_busy_done", id), 32'(busy), 32'd0);
    if (v.done_at != 0)
      check($sformatf("v%0d_done_cycle", id),
            32'(done_k), 32'(v.done_at));
    if (v.len != 0)
      check($sformatf("v%0d_last_addr", id),
            32'(last), 32'(v.last_addr));
    @(negedge clk);
    start       = 1'b0;
    sif.ready_i = 1'b1;
    #1;
    check($sformatf("v%0d_done_pulse", id), 32'(done), 32'd0);
    check($sformatf("v%0d_idle_busy", id), 32'(busy), 32'd0);
    check($sformatf("v%0d_idle_cen", id), 32'(cen), 32'd1);
    check($sformatf("v%0d_idle_valid", id),
          32'(sif.valid_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t rv;
    int   n_vec;
    int   npop;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{8'h10, 9'd4, 8'h01, 16'hFFFF, 8'h13, 7, 1'b0};
    vecs[1] = '{8'hFE, 9'd4, 8'h01, 16'hFFFF, 8'h01, 7, 1'b0};
    vecs[2] = '{8'h20, 9'd8, 8'h01, 16'h9999, 8'h27, 0, 1'b0};
    vecs[3] = '{8'h80, 9'd1, 8'h01, 16'hFFFF, 8'h80, 4, 1'b0};
    vecs[4] = '{8'h00, 9'd0, 8'h01, 16'hFFFF, 8'h00, 1, 1'b0};
    vecs[5] = '{8'h40, 9'd5, 8'h01, 16'hFFF8, 8'h44, 0, 1'b0};
    vecs[6] = '{8'h30, 9'd6, 8'h01, 16'hFFFF, 8'h35, 9, 1'b1};
    n_vec = 7;
`ifdef RAM_BURST_RD_STRIDE_EN
    vecs[7] = '{8'h00, 9'd5, 8'h40, 16'hFFFF, 8'h00, 8, 1'b0};
    n_vec = 8;
`endif

    rst_n       = 1'b0;
    start       = 1'b0;
    base        = 8'h0;
    len         = 9'd0;
    stride      = 8'h01;
    sif.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset("post_rst");

    for (int i = 0; i < n_vec; i++) run_burst(vecs[i], i);

    // Reset asserted after two of six words have left.
    @(negedge clk);
    start       = 1'b1;
    base        = 8'h50;
    len         = 9'd6;
    stride      = 8'h01;
    sif.ready_i = 1'b1;
    npop        = 0;
    for (int k = 1; k <= 40 && npop < 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (sif.valid_o && sif.ready_i) npop++;
    end
    check("mid_rst_pops", 32'(npop), 32'd2);
    check("mid_rst_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    #1;
    check_reset("mid_rst_hold");
    rst_n = 1'b1;
    rv = '{8'h60, 9'd3, 8'h01, 16'hFFFF, 8'h62, 6, 1'b0};
    run_burst(rv, 100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_rd.md
Name: ram_burst_rd

Overview:
Burst read initiator for one port of the dual-port RAM model (active-low cen/wen/oen, one-cycle registered read latency). It accepts a base address and word count, issues sequential read accesses on the RAM port, and streams the returned words out on a valid/ready interface. Backpressure is absorbed by a 2-entry output buffer with credit-based issue. Used by pipeline stages that drain line/coefficient buffers written by a producer on the other RAM port.

Parameters:
Word_Width  32  RAM word / output data width
Addr_Width  8   RAM address width; addresses wrap modulo 2^Addr_Width
Len_Width   9   width of burst length field (max 2^Len_Width-1 words)

Ports:
clk          input   1           clock
rst_n        input   1           asynchronous reset, active low
start_i      input   1           burst request, sampled only when busy_o=0
base_i       input   Addr_Width  first read address, sampled with start_i
len_i        input   Len_Width   number of words, sampled with start_i
busy_o       output  1           burst in progress
done_o       output  1           one-cycle pulse at burst completion
ram_cen_o    output  1           RAM chip enable, active low
ram_oen_o    output  1           RAM output enable, active low
ram_wen_o    output  1           RAM write enable, active low; tied 1 (never writes)
ram_addr_o   output  Addr_Width  RAM address
ram_data_i   input   Word_Width  RAM read data
valid_o      output  1           output word valid
ready_i      input   1           downstream ready
data_o       output  Word_Width  output word

Behaviour:
- Reset values: busy_o=0, done_o=0, ram_cen_o=1, ram_oen_o=1, ram_wen_o=1, ram_addr_o=0, valid_o=0, data_o=0; buffer empty; state IDLE.
- Clock is single; reset is asynchronous assertion, active low, and returns everything to the reset values regardless of the burst in progress. Any in-flight RAM data is discarded.
- States:
  - IDLE: on start_i=1 with len_i!=0, latch base/len, go to ISSUE, busy_o=1 next cycle. On start_i=1 with len_i=0, pulse done_o next cycle with no RAM access and busy_o staying 0.
  - ISSUE: issue reads until len words have been issued, then go to DRAIN.
  - DRAIN: wait until all issued words have handshaken out, then go to IDLE, pulse done_o, and drop busy_o in the same cycle.
- start_i while busy_o=1 is ignored.
- ram_oen_o=0 whenever the state is not IDLE.
- Issue rule: in a cycle where issue is permitted, ram_cen_o=0 and ram_addr_o=current address. Issue is permitted when (buffer occupancy + in-flight reads - pop this cycle) < 2. Otherwise ram_cen_o=1 and the address is held.
- The address increments by 1 per issued read and wraps from 2^Addr_Width-1 to 0.
- Read data returns on ram_data_i the cycle after issue and is written into the buffer at the end of that cycle. valid_o/data_o are driven from the buffer head.
- Timing with ready_i held 1: start in cycle T, first ram_cen_o=0 in T+1, first valid_o in T+3. Throughput is then 1 word/cycle, with no bubbles.
- Handshake: a word transfers when valid_o&ready_i. data_o stays stable while valid_o=1 and ready_i=0. The buffer never overflows: a push coinciding with a full buffer is impossible by construction, and an assertion checks it.
- A simultaneous push and pop keeps the occupancy unchanged, with FIFO order preserved.
- done_o fires in the cycle after the last word's handshake.

Optional Feature:
- Macro: RAM_BURST_RD_STRIDE_EN.
- Defined: adds input stride_i [Addr_Width-1:0], sampled with start_i. The address increments by stride (mod 2^Addr_Width) per issued read. stride=0 rereads the base address len times.
- Undefined: the port is absent and the increment is fixed at 1.

Test Plan:
- base=0x10, len=4, ready_i=1 with RAM preloaded mem[a]=a+0x100 -> ram_cen_o=0 in T+1..T+4 at addresses 0x10..0x13; data_o 0x110..0x113 in T+3..T+6; done_o in T+7.
- base=0xFE, len=4 -> addresses 0xFE,0xFF,0x00,0x01 (wrap); data order matches.
- len=8 with ready_i toggled 1,0,0,1,... -> no lost or duplicated words; ram_cen_o=1 while occupancy+inflight=2; data_o stable during stalls.
- len=0 -> done_o one cycle after start, no ram_cen_o=0, busy_o stays 0. start_i pulsed mid-burst -> ignored.
- rst_n asserted low mid-burst (after 2 of 6 words) -> all outputs at reset values immediately; new burst len=3 after release completes correctly.
- RAM_BURST_RD_STRIDE_EN defined, base=0x00, stride=0x40, len=5 -> addresses 0x00,0x40,0x80,0xC0,0x00.
